// File: rtl/fx3_packet_scheduler_pkg.sv
// Shared definitions for the FX3 packet scheduler: default sizing and state encodings.
package fx3_packet_scheduler_pkg;

  localparam int unsigned DEF_DATA_W       = 16;
  localparam int unsigned DEF_PACKET_WORDS = 8192;
  localparam int unsigned DEF_LEVEL_W      = 15;
  localparam int unsigned DEF_GAP_CYCLES   = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    WAIT_FX3  = 3'd2,
    SEND      = 3'd3,
    GAP       = 3'd4
  } schedState_t;

  function automatic logic isBusyState(input schedState_t s);
    return (s == SEND) || (s == GAP);
  endfunction

endpackage

// File: rtl/fx3_packet_scheduler.sv
// Streams fixed-size packets from the sample FIFO onto the FX3 GPIF-II slave bus
// once a full packet is buffered and the FX3 reports ready; tracks status for the host.
module fx3_packet_scheduler
  import fx3_packet_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned PACKET_WORDS = DEF_PACKET_WORDS,
  parameter int unsigned LEVEL_W      = DEF_LEVEL_W,
  parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic               inclk,
  input  logic               reset,
  input  logic               captureEnable,
  input  logic [LEVEL_W-1:0] fifoLevel,
  input  logic               fifoFull,
  input  logic [DATA_W-1:0]  fifoData,
  output logic               fifoRead,
  input  logic               fx3Ready,
  output logic               fx3Write,
  output logic [DATA_W-1:0]  fx3Data,
  output logic               busy,
  output logic [31:0]        packetCount,
  output logic               overflowFlag,
  output logic               protocolError
);

  localparam int unsigned        CNT_W     = $clog2(PACKET_WORDS);
  localparam logic [LEVEL_W-1:0] PKT_LEVEL = LEVEL_W'(PACKET_WORDS);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(PACKET_WORDS - 1);
  localparam logic [CNT_W-1:0]   LAST_GAP  = CNT_W'(GAP_CYCLES - 1);

  schedState_t      state, nextState;
  logic [CNT_W-1:0] beatCnt, nextCnt;
  logic             readyQ;
  logic             enableQ;
  logic             levelOk;
  logic             enableRise;
  logic             packetDone;

  assign levelOk    = fifoLevel >= PKT_LEVEL;
  assign enableRise = captureEnable & ~enableQ;
  assign packetDone = (state == SEND) && (beatCnt == LAST_BEAT);

  // Next-state logic; one counter serves as beat count in SEND and gap count in GAP.
  always_comb begin
    nextState = state;
    nextCnt   = '0;
    case (state)
      IDLE: begin
        if (captureEnable) nextState = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (!captureEnable) nextState = IDLE;
        else if (levelOk)   nextState = WAIT_FX3;
      end
      WAIT_FX3: begin
        if (!captureEnable)         nextState = IDLE;
        else if (readyQ && levelOk) nextState = SEND;
      end
      SEND: begin
        if (beatCnt == LAST_BEAT) nextState = GAP;
        else                      nextCnt   = beatCnt + CNT_W'(1);
      end
      GAP: begin
        if (beatCnt == LAST_GAP) nextState = captureEnable ? WAIT_DATA : IDLE;
        else                     nextCnt   = beatCnt + CNT_W'(1);
      end
      default: nextState = IDLE;
    endcase
  end

  // State, counter and input flops; strobes are registered copies of the next-state decode.
  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beatCnt  <= '0;
      readyQ   <= 1'b0;
      enableQ  <= 1'b0;
      fifoRead <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= nextState;
      beatCnt  <= nextCnt;
      readyQ   <= fx3Ready;
      enableQ  <= captureEnable;
      fifoRead <= (nextState == SEND);
      busy     <= isBusyState(nextState);
    end
  end

  // GPIF pipeline: fx3Write is fifoRead delayed, and gates capture of the returned FIFO word.
  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      fx3Write <= 1'b0;
      fx3Data  <= '0;
    end else begin
      fx3Write <= fifoRead;
      if (fx3Write) fx3Data <= fifoData;
    end
  end

  // Status: packet counter and sticky flags (a set in the same cycle as a clear wins).
  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      packetCount   <= '0;
      overflowFlag  <= 1'b0;
      protocolError <= 1'b0;
    end else begin
      if (packetDone) packetCount <= packetCount + 32'd1;

      if (fifoFull && captureEnable) overflowFlag <= 1'b1;
      else if (enableRise)           overflowFlag <= 1'b0;

      if ((state == SEND) && !readyQ) protocolError <= 1'b1;
      else if (enableRise)            protocolError <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fx3_packet_scheduler.sv
// Directed bench for fx3_packet_scheduler: start-condition table plus multi-cycle packet sequences.
module tb_fx3_packet_scheduler;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned PW      = 8192;
  localparam int unsigned LEVEL_W = 15;

  logic               inclk = 1'b0;
  logic               reset;
  logic               captureEnable;
  logic [LEVEL_W-1:0] fifoLevel;
  logic               fifoFull;
  logic [DATA_W-1:0]  fifoData;
  logic               fifoRead;
  logic               fx3Ready;
  logic               fx3Write;
  logic [DATA_W-1:0]  fx3Data;
  logic               busy;
  logic [31:0]        packetCount;
  logic               overflowFlag;
  logic               protocolError;

  always #5 inclk = ~inclk;

  fx3_packet_scheduler dut (
    .inclk        (inclk),
    .reset        (reset),
    .captureEnable(captureEnable),
    .fifoLevel    (fifoLevel),
    .fifoFull     (fifoFull),
    .fifoData     (fifoData),
    .fifoRead     (fifoRead),
    .fx3Ready     (fx3Ready),
    .fx3Write     (fx3Write),
    .fx3Data      (fx3Data),
    .busy         (busy),
    .packetCount  (packetCount),
    .overflowFlag (overflowFlag),
    .protocolError(protocolError)
  );

  int checks = 0;
  int errors = 0;
  int readCnt, writeCnt, readRuns, lagErr, dataErr;
  logic [DATA_W-1:0] expData;
  logic [DATA_W-1:0] wordNext;

  typedef struct {
    string              name;
    logic               en;
    logic [LEVEL_W-1:0] level;
    logic               ready;
    logic               full;
    int                 expStart;
    logic               expBusy;
    logic               expOvf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clearStats();
    readCnt  = 0;
    writeCnt = 0;
    readRuns = 0;
    lagErr   = 0;
    dataErr  = 0;
  endtask

  // One clock: FIFO model returns a word the cycle after a read; bus expectation follows fx3Write.
  task automatic tick();
    logic r, w;
    logic [DATA_W-1:0] d;
    r = fifoRead;
    w = fx3Write;
    d = fifoData;
    @(posedge inclk);
    #1;
    if (w) expData = d;
    if (r) begin
      fifoData = wordNext;
      wordNext = wordNext + 16'd1;
    end
    readCnt  += int'(fifoRead);
    writeCnt += int'(fx3Write);
    if (fifoRead && !r) readRuns++;
    if (fx3Write != r) lagErr++;
    if (fx3Data != expData) dataErr++;
  endtask

  task automatic doReset();
    reset         = 1'b1;
    captureEnable = 1'b0;
    fifoLevel     = '0;
    fifoFull      = 1'b0;
    fx3Ready      = 1'b0;
    fifoData      = '0;
    expData       = '0;
    wordNext      = 16'h1000;
    repeat (2) @(posedge inclk);
    #1;
    reset = 1'b0;
    clearStats();
  endtask

  task automatic waitStart(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (fifoRead) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic finishPacket(input string name);
    int k;
    k = 0;
    while (fifoRead && k < 9000) begin
      tick();
      k++;
    end
    check({name, " read ends"}, longint'(fifoRead), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] pcPrev;

    vecs[0] = '{"lvl0",     1'b1, 15'd0,     1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[1] = '{"lvl8191",  1'b1, 15'd8191,  1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[2] = '{"noReady",  1'b1, 15'd8192,  1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[3] = '{"disabled", 1'b0, 15'd8192,  1'b1, 1'b1, 0, 1'b0, 1'b0};
    vecs[4] = '{"exact",    1'b1, 15'd8192,  1'b1, 1'b0, 3, 1'b1, 1'b0};
    vecs[5] = '{"lvlMax",   1'b1, 15'd32767, 1'b1, 1'b1, 3, 1'b1, 1'b1};
    vecs[6] = '{"lvl16384", 1'b1, 15'd16384, 1'b1, 1'b0, 3, 1'b1, 1'b0};
    vecs[7] = '{"lvl8193",  1'b1, 15'd8193,  1'b1, 1'b0, 3, 1'b1, 1'b0};

    doReset();
    check("rst fifoRead", longint'(fifoRead), 0);
    check("rst fx3Write", longint'(fx3Write), 0);
    check("rst fx3Data", longint'(fx3Data), 0);
    check("rst busy", longint'(busy), 0);
    check("rst packetCount", longint'(packetCount), 0);
    check("rst overflowFlag", longint'(overflowFlag), 0);
    check("rst protocolError", longint'(protocolError), 0);

    // Start conditions from a fresh reset
    foreach (vecs[i]) begin
      doReset();
      captureEnable = vecs[i].en;
      fifoLevel     = vecs[i].level;
      fx3Ready      = vecs[i].ready;
      fifoFull      = vecs[i].full;
      waitStart(12, n);
      check({vecs[i].name, " start"}, n, vecs[i].expStart);
      check({vecs[i].name, " busy"}, longint'(busy), longint'(vecs[i].expBusy));
      check({vecs[i].name, " ovf"}, longint'(overflowFlag), longint'(vecs[i].expOvf));
    end

    // Test 1: one full packet, write lag, packet count timing, gap length
    doReset();
    fifoLevel = 15'd8192; fx3Ready = 1'b1; captureEnable = 1'b1;
    waitStart(10, n);
    check("t1 start", n, 3);
    fifoLevel = '0;
    pcPrev = packetCount;
    for (int k = 0; k < 9000 && fifoRead; k++) begin
      pcPrev = packetCount;
      tick();
    end
    check("t1 reads", readCnt, PW);
    check("t1 writes", writeCnt, PW);
    check("t1 runs", readRuns, 1);
    check("t1 pc before", longint'(pcPrev), 0);
    check("t1 pc after", longint'(packetCount), 1);
    check("t1 last write", longint'(fx3Write), 1);
    check("t1 gap busy0", longint'(busy), 1);
    tick();
    check("t1 gap busy1", longint'(busy), 1);
    check("t1 write off", longint'(fx3Write), 0);
    tick();
    check("t1 gap done", longint'(busy), 0);
    check("t1 last word", longint'(fx3Data), 32'h2FFF);
    check("t1 lag errs", lagErr, 0);
    check("t1 data errs", dataErr, 0);

    // Test 2: level one short of a packet holds off reads
    doReset();
    fifoLevel = 15'd8191; fx3Ready = 1'b1; captureEnable = 1'b1;
    repeat (100) tick();
    check("t2 no read", readCnt, 0);
    check("t2 not busy", longint'(busy), 0);
    fifoLevel = 15'd8192;
    waitStart(10, n);
    check("t2 start", n, 2);
    fifoLevel = '0;
    finishPacket("t2");
    check("t2 reads", readCnt, PW);
    check("t2 runs", readRuns, 1);

    // Test 3: FX3 not ready, SEND two cycles after ready rises
    doReset();
    fifoLevel = 15'd8192; fx3Ready = 1'b0; captureEnable = 1'b1;
    repeat (50) tick();
    check("t3 no read", readCnt, 0);
    fx3Ready = 1'b1;
    waitStart(10, n);
    check("t3 start", n, 2);
    fifoLevel = '0;
    finishPacket("t3");
    check("t3 reads", readCnt, PW);

    // Test 4: disable mid-packet completes the packet then idles
    doReset();
    fifoLevel = 15'd8192; fx3Ready = 1'b1; captureEnable = 1'b1;
    waitStart(10, n);
    check("t4 start", n, 3);
    repeat (4000) tick();
    captureEnable = 1'b0;
    finishPacket("t4");
    check("t4 reads", readCnt, PW);
    check("t4 pc", longint'(packetCount), 1);
    tick();
    check("t4 gap", longint'(busy), 1);
    tick();
    check("t4 idle", longint'(busy), 0);
    repeat (50) tick();
    check("t4 no more reads", readCnt, PW);
    check("t4 writes", writeCnt, PW);
    check("t4 data errs", dataErr, 0);

    // Test 5: ready drop during SEND, then sticky clear behaviour
    doReset();
    fifoLevel = 15'd8192; fx3Ready = 1'b1; captureEnable = 1'b1;
    waitStart(10, n);
    fifoLevel = '0;
    repeat (100) tick();
    fx3Ready = 1'b0;
    tick();
    check("t5 perr lag", longint'(protocolError), 0);
    tick();
    check("t5 perr set", longint'(protocolError), 1);
    finishPacket("t5");
    check("t5 reads", readCnt, PW);
    check("t5 runs", readRuns, 1);
    tick();
    check("t5 writes", writeCnt, PW);
    check("t5 perr sticky", longint'(protocolError), 1);
    tick();
    fifoFull = 1'b1;
    tick();
    check("t5 ovf set", longint'(overflowFlag), 1);
    fifoFull = 1'b0; captureEnable = 1'b0;
    tick();
    check("t5 ovf fall kept", longint'(overflowFlag), 1);
    check("t5 perr fall kept", longint'(protocolError), 1);
    captureEnable = 1'b1; fifoFull = 1'b1;
    tick();
    check("t5 ovf set wins", longint'(overflowFlag), 1);
    check("t5 perr cleared", longint'(protocolError), 0);
    fifoFull = 1'b0; captureEnable = 1'b0;
    tick();
    captureEnable = 1'b1;
    tick();
    check("t5 ovf cleared", longint'(overflowFlag), 0);

    // Test 6: asynchronous reset in the middle of a packet
    fx3Ready = 1'b1; fifoLevel = 15'd8192;
    clearStats();
    waitStart(10, n);
    check("t6 start", longint'(n > 0), 1);
    fifoLevel = '0; fifoFull = 1'b1;
    tick();
    fifoFull = 1'b0;
    repeat (8) tick();
    check("t6 pre ovf", longint'(overflowFlag), 1);
    check("t6 pre pc", longint'(packetCount), 1);
    check("t6 pre read", longint'(fifoRead), 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6 fifoRead", longint'(fifoRead), 0);
    check("t6 fx3Write", longint'(fx3Write), 0);
    check("t6 busy", longint'(busy), 0);
    check("t6 packetCount", longint'(packetCount), 0);
    check("t6 overflowFlag", longint'(overflowFlag), 0);
    check("t6 fx3Data", longint'(fx3Data), 0);
    doReset();
    fifoLevel = 15'd8192; fx3Ready = 1'b1;
    repeat (20) tick();
    check("t6 idle after reset", readCnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
